tx_gearbox_6664: RTL

//  TX gearbox downstream of the 64b/66b encoder and scrambler. Packs 66-bit blocks
//  ({o_tx_header, scrambled txd}) into a continuous 64-bit word stream for the transceiver.
//  32 blocks = 2112 bits = 33 words, so the block inserts one pause cycle per 33 cycles.
//  It drives o_tx_pause back to the encoder and scrambler, which hold state while it is high.

---
 rtl/tx_gearbox_6664.sv | 78 +++++++
 1 files changed

// File: rtl/tx_gearbox_6664.sv
// 66b -> 64b TX gearbox: packs 32 sync-headed blocks into 33 transceiver words,
// stalling upstream for one cycle in every 33 via o_tx_pause.
module tx_gearbox_6664 #(
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic        i_txc,
    input  logic        i_reset,
    input  logic        i_init_done,
    input  logic [63:0] i_txd,
    input  logic [1:0]  i_tx_header,
    output logic [63:0] o_txd,
    output logic        o_tx_pause,
    output logic [5:0]  o_seq
);

    localparam logic [5:0] PAUSE_SEQ = 6'd32;

    logic [5:0]   seq_q, seq_d;
    logic [63:0]  res_q, res_d;
    logic [63:0]  word_q, word_d;
    logic         pause_q, pause_d;
    logic [6:0]   res_cnt;
    logic [127:0] stream;

    // Residual never exceeds 64 bits: before a capture it holds at most 62 bits,
    // so the top half of the 128-bit window is all that survives the shift.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        seq_d   = seq_q;
        res_d   = res_q;
        word_d  = word_q;
        res_cnt = {seq_q, 1'b0};
        stream  = {64'd0, res_q} | ({62'd0, i_txd, i_tx_header} << res_cnt);

        if (!i_init_done) begin
            seq_d  = '0;
            res_d  = '0;
            word_d = '0;
        end else if (seq_q == PAUSE_SEQ) begin
            word_d = res_q;
            res_d  = '0;
            seq_d  = '0;
        end else begin
            word_d = stream[63:0];
            res_d  = stream[127:64];
            seq_d  = seq_q + 6'd1;
        end

        pause_d = (seq_d == PAUSE_SEQ);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_txc) begin
        if (i_reset) begin
            seq_q   <= '0;
            res_q   <= '0;
            word_q  <= '0;
            pause_q <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            res_q   <= res_d;
            word_q  <= word_d;
            pause_q <= pause_d;
        end
    end

    if (BIT_REVERSE) begin : g_rev
        always_comb begin
            for (int i = 0; i < 64; i++) o_txd[i] = word_q[63-i];
        end
    end else begin : g_fwd
        assign o_txd = word_q;
    end

    assign o_tx_pause = pause_q;
    assign o_seq      = seq_q;

endmodule
